// File: rtl/toggle_fsm_bank.sv
// Bank of CH independent on/off toggle FSMs with LEVEL, EDGE and debounced HOLD qualification.
// Outputs are registered: per-channel state, one-cycle toggle pulses and an ON-channel count.
//
//   state | meaning
//   ------+-------------------------------
//   S_OFF | channel output y[i] = 0
//   S_ON  | channel output y[i] = 1
module toggle_fsm_bank #(
  parameter int CH   = 4,
  parameter int HOLD = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic [CH-1:0]              x,
  output logic [CH-1:0]              y,
  output logic [CH-1:0]              tgl,
  output logic [$clog2(CH+1)-1:0]    on_cnt
);

  localparam int CNT_W = $clog2(HOLD + 1);
  localparam int ON_W  = $clog2(CH + 1);

  typedef enum logic {S_OFF = 1'b0, S_ON = 1'b1} state_t;
  typedef enum logic [1:0] {M_LEVEL = 2'b00, M_EDGE = 2'b01, M_HOLD = 2'b10, M_FREEZE = 2'b11} mode_t;

  state_t           s        [CH];
  state_t           s_nxt    [CH];
  logic [CNT_W-1:0] cnt      [CH];
  logic [CNT_W-1:0] cnt_nxt  [CH];
  logic [CH-1:0]    lock;
  logic [CH-1:0]    lock_nxt;
  logic [CH-1:0]    x_q;
  logic [1:0]       mode_q;
  logic             mode_chg;
  logic [ON_W-1:0]  on_nxt;

  assign mode_chg = (mode != mode_q);

  // Press progress (cnt/lock) defaults to cleared; only an uninterrupted HOLD press keeps it.
  always_comb begin
    on_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      s_nxt[i]    = s[i];
      cnt_nxt[i]  = '0;
      lock_nxt[i] = 1'b0;
      if (!clr && en) begin
        unique case (mode_t'(mode))
          M_LEVEL: begin
            if (x[i]) s_nxt[i] = (s[i] == S_ON) ? S_OFF : S_ON;
          end
          M_EDGE: begin
            if (x[i] && !x_q[i]) s_nxt[i] = (s[i] == S_ON) ? S_OFF : S_ON;
          end
          M_HOLD: begin
            if (!mode_chg && x[i]) begin
              if (lock[i]) begin
                lock_nxt[i] = 1'b1;
              end else if (cnt[i] == CNT_W'(HOLD - 1)) begin
                s_nxt[i]    = (s[i] == S_ON) ? S_OFF : S_ON;
                lock_nxt[i] = 1'b1;
              end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
              end
            end
          end
          M_FREEZE: ;
          default: ;
        endcase
      end
      if (clr) s_nxt[i] = S_OFF;
      on_nxt = on_nxt + ON_W'(s_nxt[i] == S_ON);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        s[i]   <= S_OFF;
        cnt[i] <= '0;
      end
      lock   <= '0;
      x_q    <= '0;
      mode_q <= 2'b00;
      tgl    <= '0;
      on_cnt <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        s[i]   <= s_nxt[i];
        cnt[i] <= cnt_nxt[i];
        tgl[i] <= !clr && (s_nxt[i] != s[i]);
      end
      lock   <= lock_nxt;
      x_q    <= x;
      mode_q <= mode;
      on_cnt <= on_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) y[i] = (s[i] == S_ON);
  end

endmodule
